// File: rtl/io_port_ctrl.sv
// Memory-mapped I/O controller: switch synchronise/debounce with change events,
// plus value/blanking registers driving six active-low 7-segment digits.
module io_port_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SW_WIDTH        = 10
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                io_sel,
    input  logic                io_we,
    input  logic [1:0]          io_addr,
    input  logic [31:0]         io_wdata,
    output logic [31:0]         io_rdata,
    input  logic [SW_WIDTH-1:0] sw,
    output logic [6:0]          hex5,
    output logic [6:0]          hex4,
    output logic [6:0]          hex3,
    output logic [6:0]          hex2,
    output logic [6:0]          hex1,
    output logic [6:0]          hex0,
    output logic                sw_irq
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ADDR_SW_STATE  = 2'd0,
        ADDR_SW_EVENT  = 2'd1,
        ADDR_HEX_VAL   = 2'd2,
        ADDR_HEX_BLANK = 2'd3
    } reg_addr_t;

    logic [SW_WIDTH-1:0] sync1;
    logic [SW_WIDTH-1:0] sync2;
    logic [SW_WIDTH-1:0] sw_db;
    logic [CNT_W-1:0]    cnt [SW_WIDTH];
    logic [SW_WIDTH-1:0] accept;
    logic [SW_WIDTH-1:0] sw_event;
    logic [SW_WIDTH-1:0] event_clear;
    logic [23:0]         hex_val;
    logic [5:0]          hex_blank;
    logic [6:0]          seg [6];
    reg_addr_t           addr;
    logic                wr;
    logic                unused_wdata;

    assign addr = reg_addr_t'(io_addr);
    assign wr   = io_sel & io_we;

    // Upper write-data bits have no backing storage in any register.
    assign unused_wdata = ^io_wdata[31:24];

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0:    seg7 = 7'b1000000;
            4'h1:    seg7 = 7'b1111001;
            4'h2:    seg7 = 7'b0100100;
            4'h3:    seg7 = 7'b0110000;
            4'h4:    seg7 = 7'b0011001;
            4'h5:    seg7 = 7'b0010010;
            4'h6:    seg7 = 7'b0000010;
            4'h7:    seg7 = 7'b1111000;
            4'h8:    seg7 = 7'b0000000;
            4'h9:    seg7 = 7'b0010000;
            4'hA:    seg7 = 7'b0001000;
            4'hB:    seg7 = 7'b0000011;
            4'hC:    seg7 = 7'b1000110;
            4'hD:    seg7 = 7'b0100001;
            4'hE:    seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    // A bit is accepted once the synchronised level has differed from sw_db
    // for DEBOUNCE_CYCLES consecutive edges.
    always_comb begin
        for (int i = 0; i < SW_WIDTH; i++) begin
            accept[i] = (sync2[i] != sw_db[i]) && (cnt[i] == CNT_LAST);
        end
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values;
    // blocking assignments here would collapse the two synchroniser stages.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            sw_db <= '0;
            // NOTE: the counter array is reset too, so a reset mid-debounce
            // discards any partial count instead of letting it resume.
            for (int i = 0; i < SW_WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= sw;
            sync2 <= sync1;
            for (int i = 0; i < SW_WIDTH; i++) begin
                if (sync2[i] == sw_db[i]) begin
                    cnt[i] <= '0;
                end else if (accept[i]) begin
                    sw_db[i] <= sync2[i];
                    cnt[i]   <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign event_clear = (wr && addr == ADDR_SW_EVENT) ? io_wdata[SW_WIDTH-1:0] : '0;

    // A new event in the same cycle as its W1C wins, so no change is lost.
    always_ff @(posedge clock) begin
        if (reset) begin
            sw_event  <= '0;
            hex_val   <= '0;
            hex_blank <= '0;
        end else begin
            sw_event <= (sw_event & ~event_clear) | accept;
            if (wr && addr == ADDR_HEX_VAL) begin
                hex_val <= io_wdata[23:0];
            end
            if (wr && addr == ADDR_HEX_BLANK) begin
                hex_blank <= io_wdata[5:0];
            end
        end
    end

    assign sw_irq = |sw_event;

    // NOTE: io_rdata gets a default before the case so no path infers a latch.
    always_comb begin
        io_rdata = 32'h0;
        if (io_sel) begin
            case (addr)
                ADDR_SW_STATE:  io_rdata = 32'(sw_db);
                ADDR_SW_EVENT:  io_rdata = 32'(sw_event);
                ADDR_HEX_VAL:   io_rdata = {8'h00, hex_val};
                ADDR_HEX_BLANK: io_rdata = {26'h0, hex_blank};
                default:        io_rdata = 32'h0;
            endcase
        end
    end

    always_comb begin
        for (int k = 0; k < 6; k++) begin
            seg[k] = hex_blank[k] ? 7'b1111111 : seg7(hex_val[4*k +: 4]);
        end
    end

    assign hex0 = seg[0];
    assign hex1 = seg[1];
    assign hex2 = seg[2];
    assign hex3 = seg[3];
    assign hex4 = seg[4];
    assign hex5 = seg[5];

endmodule

// File: tb/tb_io_port_ctrl.sv
// Directed self-checking bench for io_port_ctrl (DEBOUNCE_CYCLES=4, SW_WIDTH=10).
module tb_io_port_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_sel;
    logic        io_we;
    logic [1:0]  io_addr;
    logic [31:0] io_wdata;
    logic [31:0] io_rdata;
    logic [9:0]  sw;
    logic [6:0]  hex5, hex4, hex3, hex2, hex1, hex0;
    logic        sw_irq;

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    io_port_ctrl #(.DEBOUNCE_CYCLES(4), .SW_WIDTH(10)) dut (
        .clock(clock), .reset(reset), .io_sel(io_sel), .io_we(io_we),
        .io_addr(io_addr), .io_wdata(io_wdata), .io_rdata(io_rdata), .sw(sw),
        .hex5(hex5), .hex4(hex4), .hex3(hex3), .hex2(hex2), .hex1(hex1),
        .hex0(hex0), .sw_irq(sw_irq)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        io_sel  = 1'b1;
        io_we   = 1'b0;
        io_addr = a;
        #1;
        d = io_rdata;
        io_sel = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        io_sel   = 1'b1;
        io_we    = 1'b1;
        io_addr  = a;
        io_wdata = d;
        tick();
        io_sel = 1'b0;
        io_we  = 1'b0;
    endtask

    task automatic check_hex(input string tag, input logic [41:0] exp);
        check({tag, "_h5"}, 32'(hex5), 32'(exp[41:35]));
        check({tag, "_h4"}, 32'(hex4), 32'(exp[34:28]));
        check({tag, "_h3"}, 32'(hex3), 32'(exp[27:21]));
        check({tag, "_h2"}, 32'(hex2), 32'(exp[20:14]));
        check({tag, "_h1"}, 32'(hex1), 32'(exp[13:7]));
        check({tag, "_h0"}, 32'(hex0), 32'(exp[6:0]));
    endtask

    initial begin
        logic [31:0] d;

        reset = 1'b1; io_sel = 1'b0; io_we = 1'b0; io_addr = 2'd0;
        io_wdata = 32'h0; sw = '0;

        // Reset held three cycles
        repeat (3) tick();
        reset = 1'b0;
        check_hex("rst", {6{7'h40}});
        check("rst_irq", 32'(sw_irq), 32'h0);
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), d);
            check($sformatf("rst_rd%0d", a), d, 32'h0);
        end

        // Debounce: sw[8] rise lands exactly at edge 6
        sw[8] = 1'b1;
        repeat (5) tick();
        rd(2'd0, d); check("db_e5_state", d, 32'h0);
        tick();
        rd(2'd0, d); check("db_e6_state", d, 32'h100);
        rd(2'd1, d); check("db_e6_event", d, 32'h100);

        // A 3-cycle glitch on sw[3] must be rejected
        sw[3] = 1'b1;
        repeat (3) tick();
        sw[3] = 1'b0;
        repeat (8) tick();
        rd(2'd0, d); check("glitch_state", d, 32'h100);
        rd(2'd1, d); check("glitch_event", d, 32'h100);

        // Events and W1C
        sw[3] = 1'b1;
        repeat (6) tick();
        rd(2'd1, d); check("ev_both", d, 32'h108);
        check("ev_irq", 32'(sw_irq), 32'h1);
        rd(2'd0, d); check("ev_state", d, 32'h108);
        wr(2'd1, 32'h100);
        rd(2'd1, d); check("w1c_bit8", d, 32'h008);
        check("w1c_irq", 32'(sw_irq), 32'h1);

        // sw[0] event lands on the same edge as a W1C of bit 0: set wins
        sw[0] = 1'b1;
        repeat (5) tick();
        io_sel = 1'b1; io_we = 1'b1; io_addr = 2'd1; io_wdata = 32'h1;
        #1;
        check("w1c_old_rd", io_rdata, 32'h008);
        tick();
        io_sel = 1'b0; io_we = 1'b0;
        rd(2'd1, d); check("set_wins", d, 32'h009);
        wr(2'd1, 32'h009);
        rd(2'd1, d); check("w1c_all", d, 32'h0);
        check("w1c_all_irq", 32'(sw_irq), 32'h0);

        // Display
        wr(2'd2, 32'h00ABCDEF);
        check_hex("abcdef", {7'b0001000, 7'b0000011, 7'b1000110,
                             7'b0100001, 7'b0000110, 7'b0001110});
        wr(2'd3, 32'h21);
        check_hex("blank", {7'h7F, 7'b0000011, 7'b1000110,
                            7'b0100001, 7'b0000110, 7'h7F});
        rd(2'd3, d); check("blank_rd", d, 32'h21);
        wr(2'd3, 32'hFFFF_FFC0);
        rd(2'd3, d); check("blank_mask", d, 32'h0);
        for (int v = 0; v < 16; v++) begin
            wr(2'd2, {8'h00, {6{4'(v)}}});
            check_hex($sformatf("dig%0d", v), {6{seg_tab[v]}});
        end

        // Protection
        wr(2'd0, 32'hFFFF);
        rd(2'd0, d); check("ro_state", d, 32'h109);
        wr(2'd2, 32'hFF12_3456);
        rd(2'd2, d); check("hexval_upper", d, 32'h0012_3456);
        io_sel = 1'b0; io_we = 1'b1; io_addr = 2'd2; io_wdata = 32'h0065_4321;
        #1;
        check("nosel_rdata", io_rdata, 32'h0);
        tick();
        io_we = 1'b0;
        rd(2'd2, d); check("we_nosel", d, 32'h0012_3456);

        // Reset mid-debounce: sw[5] rises, reset on edge 4
        sw[5] = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd(2'd0, d); check("mid_rst_state", d, 32'h0);
        rd(2'd2, d); check("mid_rst_hex", d, 32'h0);
        check("mid_rst_h0", 32'(hex0), 32'h40);
        repeat (5) tick();
        rd(2'd0, d); check("mid_rst_e9", d, 32'h0);
        tick();
        rd(2'd0, d); check("mid_rst_e10", d, 32'h129);
        rd(2'd1, d); check("mid_rst_ev", d, 32'h129);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
